// File: rtl/elevator_pkg.sv
// Shared elevator definitions: direction codes, floor limits, car state encoding
// and the hall-call bit index helper used by the sequencer and the distributor.
package elevator_pkg;

  localparam logic [1:0] STOP   = 2'b00;
  localparam logic [1:0] UP     = 2'b10;
  localparam logic [1:0] DOWN   = 2'b01;
  localparam logic [1:0] UPDOWN = 2'b11;

  localparam logic ON  = 1'b1;
  localparam logic OFF = 1'b0;

  localparam logic [2:0] FLOOR_MIN = 3'd1;
  localparam logic [2:0] FLOOR_MAX = 3'd7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MOVE = 2'd1,
    DOOR = 2'd2
  } carState_e;

  // UP call of floor f sits at bit 2(f-1), DOWN call right above it.
  function automatic logic [3:0] hallIdx(input logic [2:0] floor, input logic [1:0] dir);
    return {floor - 3'd1, dir == DOWN};
  endfunction

  function automatic logic [13:0] hallMask(input logic [2:0] floor, input logic [1:0] dir);
    return 14'(1) << hallIdx(floor, dir);
  endfunction

  function automatic logic [6:0] floorMask(input logic [2:0] floor);
    return 7'(1) << (floor - 3'd1);
  endfunction

endpackage

// File: rtl/request_scan.sv
// Combinational scan of a per-floor need vector relative to one floor:
// any request above, any below, and one at that floor.
module request_scan
  import elevator_pkg::*;
(
  input  logic [6:0] need,
  input  logic [2:0] floor,
  output logic       above,
  output logic       below,
  output logic       here
);

  always_comb begin
    above = OFF;
    below = OFF;
    here  = OFF;
    for (int i = 0; i < 7; i++) begin
      if (3'(i + 1) > floor) above = above | need[i];
      if (3'(i + 1) < floor) below = below | need[i];
      if (3'(i + 1) == floor) here = here | need[i];
    end
  end

endmodule

// File: rtl/car_sequencer.sv
// Per-car collective-control sequencer (IDLE/MOVE/DOOR) for the seven-floor system.
// Optional door hold input is compiled in with CAR_DOOR_HOLD_EN.
module car_sequencer
  import elevator_pkg::*;
#(
  parameter int FLOOR_TICKS = 8,
  parameter int DOOR_TICKS  = 6
) (
  input  logic        clk,
  input  logic        reset,
`ifdef CAR_DOOR_HOLD_EN
  input  logic        doorHold,
`endif
  input  logic [13:0] floorButton,
  input  logic [6:0]  carButton,
  output logic [2:0]  currentFloor,
  output logic [1:0]  direction,
  output logic        doorOpen,
  output logic [13:0] servedButton,
  output logic [6:0]  carCall
);

  localparam int FW = (FLOOR_TICKS > 1) ? $clog2(FLOOR_TICKS) : 1;
  localparam int DW = (DOOR_TICKS > 1) ? $clog2(DOOR_TICKS) : 1;
  localparam logic [FW-1:0] FLOOR_LAST = FW'(FLOOR_TICKS - 1);
  localparam logic [DW-1:0] DOOR_LAST  = DW'(DOOR_TICKS - 1);

  carState_e     state, stateN;
  logic [FW-1:0] travelCnt, travelN;
  logic [DW-1:0] dwellCnt, dwellN;
  logic [2:0]    floorN, nextFloor;
  logic [1:0]    dirN, effDir;
  logic          doorN, holdNow;
  logic [13:0]   servedN;
  logic [6:0]    carCallN, need;
  logic          aboveCur, belowCur, hereCur, aboveNext, belowNext, hereNext;
  logic          aheadCur, behindCur, aheadNext, stopNext;

`ifdef CAR_DOOR_HOLD_EN
  assign holdNow = doorHold;
`else
  assign holdNow = OFF;
`endif

  always_comb begin
    for (int i = 0; i < 7; i++) need[i] = carCall[i] | floorButton[2*i] | floorButton[2*i+1];
  end

  assign nextFloor = (direction == DOWN) ? currentFloor - 3'd1 : currentFloor + 3'd1;

  request_scan scanCur (.need(need), .floor(currentFloor),
                        .above(aboveCur), .below(belowCur), .here(hereCur));
  request_scan scanNext (.need(need), .floor(nextFloor),
                         .above(aboveNext), .below(belowNext), .here(hereNext));

  // A door opened from IDLE has no committed direction; pick one the way IDLE would.
  always_comb begin
    effDir = direction;
    if (direction == STOP) effDir = aboveCur ? UP : DOWN;
    aheadCur  = (effDir == UP) ? aboveCur : belowCur;
    behindCur = (effDir == UP) ? belowCur : aboveCur;
    aheadNext = (direction == UP) ? aboveNext : belowNext;
    stopNext  = (|(carCall & floorMask(nextFloor)))
              | (|(floorButton & hallMask(nextFloor, direction)))
              | (!aheadNext && hereNext)
              | (nextFloor == FLOOR_MAX && direction == UP)
              | (nextFloor == FLOOR_MIN && direction == DOWN);
  end

  always_comb begin
    stateN   = state;
    floorN   = currentFloor;
    dirN     = direction;
    doorN    = doorOpen;
    servedN  = '0;
    carCallN = carCall | carButton;
    travelN  = travelCnt;
    dwellN   = dwellCnt;
    case (state)
      IDLE: begin
        dirN = STOP;
        if (hereCur) begin
          stateN   = DOOR;
          doorN    = ON;
          dwellN   = '0;
          servedN  = hallMask(currentFloor, UP) | hallMask(currentFloor, DOWN);
          carCallN = carCallN & ~floorMask(currentFloor);
        end else if (aboveCur || belowCur) begin
          stateN  = MOVE;
          dirN    = aboveCur ? UP : DOWN;
          travelN = '0;
        end
      end
      MOVE: begin
        if (travelCnt == FLOOR_LAST) begin
          travelN = '0;
          floorN  = nextFloor;
          if (stopNext) begin
            stateN   = DOOR;
            doorN    = ON;
            dwellN   = '0;
            servedN  = hallMask(nextFloor, direction)
                     | (aheadNext ? 14'd0 : hallMask(nextFloor, (direction == UP) ? DOWN : UP));
            carCallN = carCallN & ~floorMask(nextFloor);
          end
        end else begin
          travelN = travelCnt + FW'(1);
        end
      end
      DOOR: begin
        carCallN = carCall | (carButton & ~floorMask(currentFloor));
        if (holdNow) begin
          dwellN = '0;
        end else if (dwellCnt == DOOR_LAST) begin
          dwellN = '0;
          doorN  = OFF;
          if (aheadCur) begin
            stateN  = MOVE;
            dirN    = effDir;
            travelN = '0;
          end else if (behindCur) begin
            stateN  = MOVE;
            dirN    = (effDir == UP) ? DOWN : UP;
            travelN = '0;
          end else begin
            stateN = IDLE;
            dirN   = STOP;
          end
        end else begin
          dwellN = dwellCnt + DW'(1);
        end
      end
      default: stateN = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      currentFloor <= FLOOR_MIN;
      direction    <= STOP;
      doorOpen     <= OFF;
      servedButton <= '0;
      carCall      <= '0;
      travelCnt    <= '0;
      dwellCnt     <= '0;
    end else begin
      state        <= stateN;
      currentFloor <= floorN;
      direction    <= dirN;
      doorOpen     <= doorN;
      servedButton <= servedN;
      carCall      <= carCallN;
      travelCnt    <= travelN;
      dwellCnt     <= dwellN;
    end
  end

endmodule

// File: tb/tb_car_sequencer.sv
// Directed bench for car_sequencer with FLOOR_TICKS=4, DOOR_TICKS=3; the door hold
// scenario is included when CAR_DOOR_HOLD_EN is defined.
module tb_car_sequencer;
  import elevator_pkg::*;

  localparam int FT = 4;
  localparam int DT = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic [13:0] floorButton;
  logic [6:0]  carButton;
  logic [2:0]  currentFloor;
  logic [1:0]  direction;
  logic        doorOpen;
  logic [13:0] servedButton;
  logic [6:0]  carCall;
`ifdef CAR_DOOR_HOLD_EN
  logic        doorHold;
`endif

  int errCount = 0;
  int checkCount = 0;
  logic [2:0] exp_q[$];

  always #5 clk = ~clk;

  car_sequencer #(.FLOOR_TICKS(FT), .DOOR_TICKS(DT)) dut (
    .clk(clk),
    .reset(reset),
`ifdef CAR_DOOR_HOLD_EN
    .doorHold(doorHold),
`endif
    .floorButton(floorButton),
    .carButton(carButton),
    .currentFloor(currentFloor),
    .direction(direction),
    .doorOpen(doorOpen),
    .servedButton(servedButton),
    .carCall(carCall)
  );

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    if (obs !== exp) begin
      errCount++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1ns after the active edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pressCar(input logic [6:0] m);
    carButton = m;
    step();
    carButton = '0;
  endtask

  task automatic waitDoor(input logic want);
    int n = 0;
    while (doorOpen !== want && n < 200) begin
      step();
      n++;
    end
    checkVal("door_wait", 32'(doorOpen), 32'(want));
  endtask

  initial begin
    logic [2:0] prevFloor;
    logic [2:0] expFloor;
    int n;
    reset = 1'b1;
    floorButton = '0;
    carButton = '0;
`ifdef CAR_DOOR_HOLD_EN
    doorHold = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    checkVal("rst_floor", 32'(currentFloor), 32'd1);
    checkVal("rst_dir", 32'(direction), 32'(STOP));
    checkVal("rst_door", 32'(doorOpen), 32'd0);
    checkVal("rst_served", 32'(servedButton), 32'd0);
    checkVal("rst_carcall", 32'(carCall), 32'd0);
    reset = 1'b0;

    // Cabin call to floor 5 with exact floor timing.
    pressCar(7'b0010000);
    checkVal("s1_latch", 32'(carCall), 32'h10);
    checkVal("s1_idle_dir", 32'(direction), 32'(STOP));
    step();
    checkVal("s1_dir_up", 32'(direction), 32'(UP));
    exp_q = '{3'd2, 3'd3, 3'd4, 3'd5};
    prevFloor = 3'd1;
    while (exp_q.size() > 0) begin
      expFloor = exp_q.pop_front();
      repeat (FT - 1) step();
      checkVal("s1_floor_hold", 32'(currentFloor), 32'(prevFloor));
      step();
      checkVal("s1_floor", 32'(currentFloor), 32'(expFloor));
      prevFloor = expFloor;
    end
    checkVal("s1_door", 32'(doorOpen), 32'd1);
    checkVal("s1_served", 32'(servedButton), 32'h0300);
    checkVal("s1_carcall_clr", 32'(carCall), 32'd0);
    carButton = 7'b0010000;
    step();
    carButton = '0;
    checkVal("s1_discard", 32'(carCall), 32'd0);
    checkVal("s1_door2", 32'(doorOpen), 32'd1);
    checkVal("s1_served_once", 32'(servedButton), 32'd0);
    step();
    checkVal("s1_door3", 32'(doorOpen), 32'd1);
    step();
    checkVal("s1_door_close", 32'(doorOpen), 32'd0);
    checkVal("s1_idle", 32'(direction), 32'(STOP));

    // Back to floor 1; UP@3 and DOWN@6.
    reset = 1'b1;
    step();
    reset = 1'b0;
    floorButton = 14'h0810;
    waitDoor(1'b1);
    checkVal("s2_floor3", 32'(currentFloor), 32'd3);
    checkVal("s2_served3", 32'(servedButton), 32'h0010);
    floorButton = 14'h0800;
    waitDoor(1'b0);
    waitDoor(1'b1);
    checkVal("s2_floor6", 32'(currentFloor), 32'd6);
    checkVal("s2_served6", 32'(servedButton), 32'h0C00);
    checkVal("s2_dir6", 32'(direction), 32'(UP));
    floorButton = '0;
    waitDoor(1'b0);
    checkVal("s2_idle", 32'(direction), 32'(STOP));

    // Park at 4, then UP@2 and DOWN@6 together.
    pressCar(7'b0001000);
    waitDoor(1'b1);
    checkVal("s3_floor4", 32'(currentFloor), 32'd4);
    waitDoor(1'b0);
    checkVal("s3_idle4", 32'(direction), 32'(STOP));
    floorButton = 14'h0804;
    step();
    checkVal("s3_tie_up", 32'(direction), 32'(UP));
    waitDoor(1'b1);
    checkVal("s3_floor6", 32'(currentFloor), 32'd6);
    checkVal("s3_served6", 32'(servedButton), 32'h0C00);
    checkVal("s3_door_dir", 32'(direction), 32'(UP));
    floorButton = 14'h0004;
    waitDoor(1'b0);
    checkVal("s3_reverse", 32'(direction), 32'(DOWN));
    waitDoor(1'b1);
    checkVal("s3_floor2", 32'(currentFloor), 32'd2);
    checkVal("s3_served2", 32'(servedButton), 32'h000C);
    floorButton = '0;
    waitDoor(1'b0);

    // Pass DOWN@3 going up to cabin call 5, serve it on the way back.
    pressCar(7'b0010000);
    step();
    step();
    floorButton = 14'h0020;
    waitDoor(1'b1);
    checkVal("s4_floor5", 32'(currentFloor), 32'd5);
    checkVal("s4_served5", 32'(servedButton), 32'h0300);
    waitDoor(1'b0);
    checkVal("s4_dir_down", 32'(direction), 32'(DOWN));
    waitDoor(1'b1);
    checkVal("s4_floor3", 32'(currentFloor), 32'd3);
    checkVal("s4_served3", 32'(servedButton), 32'h0030);
    floorButton = '0;
    waitDoor(1'b0);

    // Reset while travelling above floor 4.
    pressCar(7'b1000000);
    n = 0;
    while (currentFloor !== 3'd4 && n < 200) begin
      step();
      n++;
    end
    checkVal("s5_reach4", 32'(currentFloor), 32'd4);
    step();
    reset = 1'b1;
    #1;
    checkVal("s5_floor", 32'(currentFloor), 32'd1);
    checkVal("s5_dir", 32'(direction), 32'(STOP));
    checkVal("s5_carcall", 32'(carCall), 32'd0);
    checkVal("s5_served", 32'(servedButton), 32'd0);
    #1;
    reset = 1'b0;
    step();
    checkVal("s5_stay", 32'(direction), 32'(STOP));
    checkVal("s5_no_door", 32'(doorOpen), 32'd0);

`ifdef CAR_DOOR_HOLD_EN
    // Door opened from IDLE at floor 1 and held for 10 cycles.
    doorHold = 1'b1;
    pressCar(7'b0000001);
    step();
    checkVal("s6_served", 32'(servedButton), 32'h0003);
    for (int i = 0; i < 10; i++) begin
      if (i > 0) step();
      checkVal("s6_hold", 32'(doorOpen), 32'd1);
    end
    doorHold = 1'b0;
    for (int i = 0; i < DT; i++) begin
      if (i > 0) step();
      checkVal("s6_release", 32'(doorOpen), 32'd1);
    end
    step();
    checkVal("s6_close", 32'(doorOpen), 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule
